// File: rtl/seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// seq_mult_ctrl
//   Multi-cycle unsigned shift-add multiplier controller. It borrows the shared
//   external ripple-carry adder (reached only through the Adder* ports) for one
//   addition per cycle, WIDTH iterations per multiply. The result is the exact
//   2*WIDTH-bit product, with a one-cycle Done pulse and a registered Zero flag.
//
// Handshake: Start is sampled on a rising edge only while Ready=1 (state IDLE
//   or DONE). An accepted Start captures MultA/MultB on that edge. Start is
//   ignored while Busy=1 (state RUN). Done=1 for exactly one cycle (state DONE),
//   and Product/Zero are valid in that cycle and held until the next multiply
//   completes.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   Start             multiply request (sampled while Ready)
//   MultA, MultB      multiplicand / multiplier, captured on accepted Start
//   Ready, Busy, Done status (IDLE|DONE, RUN, DONE)
//   Product, Zero     result and Product==0 flag, registered at RUN->DONE
//   AdderA, AdderB    external adder operands (Hi, MCand in RUN; else 0)
//   AdderCin          external adder carry-in, always 0
//   AdderSum          external adder combinational sum
//   DbgState          current FSM state for observation (0 IDLE,1 RUN,2 DONE)
// ---------------------------------------------------------------------------
module seq_mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     MultA,
  input  logic [WIDTH-1:0]     MultB,
  output logic                 Ready,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Zero,
  output logic [WIDTH-1:0]     AdderA,
  output logic [WIDTH-1:0]     AdderB,
  output logic                 AdderCin,
  input  logic [WIDTH-1:0]     AdderSum,
  output logic [1:0]           DbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_mcand;
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_lo;
  logic [2*WIDTH-1:0]    r_product;
  logic                  r_zero;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_cout;
  logic                  w_c;
  logic [WIDTH-1:0]      w_hi_sel;
  logic [WIDTH-1:0]      w_hi_new;
  logic [WIDTH-1:0]      w_lo_new;

  // The adder has no carry-out, so rebuild it from the operand MSBs and the
  // sum MSB: with one operand MSB set, a carry leaves the top bit exactly when
  // a carry entered it, which is when the sum MSB came out 0.
  assign w_cout   = (r_hi[WIDTH-1] & r_mcand[WIDTH-1]) |
                    ((r_hi[WIDTH-1] | r_mcand[WIDTH-1]) & ~AdderSum[WIDTH-1]);
  assign w_hi_sel = r_lo[0] ? AdderSum : r_hi;
  assign w_c      = r_lo[0] & w_cout;
  // {C,Hi,Lo} >> 1
  assign w_hi_new = {w_c, w_hi_sel[WIDTH-1:1]};
  assign w_lo_new = {w_hi_sel[0], r_lo[WIDTH-1:1]};

  assign w_accept = Start & Ready;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST_ITER);

  // Next-state and status outputs
  always_comb begin
    w_next   = r_state;
    Ready    = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    AdderA   = '0;
    AdderB   = '0;
    AdderCin = 1'b0;
    case (r_state)
      IDLE: begin
        Ready = 1'b1;
        if (Start) w_next = RUN;
      end
      RUN: begin
        Busy   = 1'b1;
        AdderA = r_hi;
        AdderB = r_mcand;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        Ready  = 1'b1;
        Done   = 1'b1;
        w_next = Start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Datapath: capture on accept, one shift-add step per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_product <= '0;
      r_zero    <= 1'b1;
    end else if (w_accept) begin
      r_mcand <= MultA;
      r_lo    <= MultB;
      r_hi    <= '0;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_hi  <= w_hi_new;
      r_lo  <= w_lo_new;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_product <= {w_hi_new, w_lo_new};
        r_zero    <= ~|{w_hi_new, w_lo_new};
      end
    end
  end

  assign Product  = r_product;
  assign Zero     = r_zero;
  assign DbgState = r_state;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_mult_ctrl
//   Bench for seq_mult_ctrl with a behavioural adder attached to the Adder*
//   ports. The driver issues multiplies and pushes a*b plus the expected Done
//   cycle into queues; a negedge monitor pops and compares whenever Done is
//   high, and tracks the held Product value and status invariants every cycle.
// ---------------------------------------------------------------------------
module tb_seq_mult_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic                 clk;
  logic                 reset;
  logic                 Start;
  logic [WIDTH-1:0]     MultA;
  logic [WIDTH-1:0]     MultB;
  logic                 Ready;
  logic                 Busy;
  logic                 Done;
  logic [2*WIDTH-1:0]   Product;
  logic                 Zero;
  logic [WIDTH-1:0]     AdderA;
  logic [WIDTH-1:0]     AdderB;
  logic                 AdderCin;
  logic [WIDTH-1:0]     AdderSum;
  logic [1:0]           DbgState;

  seq_mult_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MultA(MultA), .MultB(MultB),
    .Ready(Ready), .Busy(Busy), .Done(Done), .Product(Product), .Zero(Zero),
    .AdderA(AdderA), .AdderB(AdderB), .AdderCin(AdderCin),
    .AdderSum(AdderSum), .DbgState(DbgState)
  );

  // External shared adder
  assign AdderSum = AdderA + AdderB + WIDTH'(AdderCin);

  // ---- clock / reset / cycle counter ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- scoreboard state ----
  logic [2*WIDTH-1:0] exp_q[$];
  int                 cyc_q[$];
  logic [2*WIDTH-1:0] model_prod = '0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%h expected=0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s timed out (cycle %0d)", name, cyc);
  endtask

  // ---- monitor ----
  always @(negedge clk) begin
    if (reset) begin
      check("rst_ready", 64'(Ready), 64'd1);
      check("rst_busy", 64'(Busy), 64'd0);
      check("rst_done", 64'(Done), 64'd0);
      check("rst_zero", 64'(Zero), 64'd1);
      check("rst_product", Product, 64'd0);
      check("rst_adder_a", 64'(AdderA), 64'd0);
      check("rst_adder_b", 64'(AdderB), 64'd0);
    end else begin
      check("ready_vs_busy", 64'(Ready), 64'(!Busy));
      check("adder_cin", 64'(AdderCin), 64'd0);
      if (!Busy) begin
        check("adder_a_quiet", 64'(AdderA), 64'd0);
        check("adder_b_quiet", 64'(AdderB), 64'd0);
      end
      if (Done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done product=0x%h with no pending multiply (cycle %0d)",
                   Product, cyc);
        end else begin
          model_prod = exp_q.pop_front();
          check("done_latency", 64'(cyc), 64'(cyc_q.pop_front()));
          check("done_product", Product, model_prod);
          check("done_zero", 64'(Zero), 64'(model_prod == '0));
        end
      end
      check("product_held", Product, model_prod);
      check("zero_held", 64'(Zero), 64'(model_prod == '0));
    end
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n = 0;
    while (!Ready && n < 200) begin
      tick();
      n++;
    end
    if (!Ready) begin
      timeout_fail("wait_ready");
    end else begin
      Start = 1'b1;
      MultA = a;
      MultB = b;
      exp_q.push_back(64'(a) * 64'(b));
      cyc_q.push_back(cyc + 1 + WIDTH);
      tick();
      Start = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !Ready) && n < 300) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || !Ready) timeout_fail("wait_drain");
  endtask

  task automatic wait_done_cycle();
    int n = 0;
    while (!Done && n < 200) begin
      tick();
      n++;
    end
    if (!Done) timeout_fail("wait_done");
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    exp_q.delete();
    cyc_q.delete();
    model_prod = '0;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  // ---- stimulus ----
  initial begin
    reset = 1'b1;
    Start = 1'b0;
    MultA = '0;
    MultB = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Basic, carry path, zero operand
    start_op(32'd3, 32'd5);
    wait_drain();
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_drain();
    start_op(32'h1234_5678, 32'd0);
    wait_drain();

    // Start during RUN is ignored
    start_op(32'd7, 32'd9);
    repeat (4) tick();
    Start = 1'b1;
    MultA = 32'd11;
    MultB = 32'd13;
    tick();
    Start = 1'b0;
    wait_drain();
    repeat (3) tick();

    // Reset mid-operation, then recover
    start_op(32'h10, 32'h10);
    repeat (9) tick();
    do_reset(2);
    tick();
    start_op(32'd2, 32'd3);
    wait_drain();

    // Back-to-back: Start held on the Done cycle
    start_op(32'hDEAD_BEEF, 32'h0000_1234);
    wait_done_cycle();
    start_op(32'h8000_0000, 32'd2);
    wait_drain();

    // Randomized, with random gaps (gap 0 lands on the Done cycle)
    for (int i = 0; i < 24; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      int gap;
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 5))
        0: a = '0;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'h8000_0000 >> $urandom_range(0, 31);
        default: ;
      endcase
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      start_op(a, b);
    end
    wait_drain();
    repeat (3) tick();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog: keeps the run bounded even if a driver loop misbehaves.
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish (cycle %0d)", cyc);
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
